// File: rtl/se_req_arbiter.sv
// Round-robin front end that shares one scrambled-eggs core among NREQ byte requesters,
// routes each core result back to its requester, and serialises host config writes.
module se_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int DEPTH   = 16,
  parameter int TIMEOUT = 100
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [8*NREQ-1:0]    req_data,
  input  logic [32*NREQ-1:0]   req_ent,
  output logic [NREQ-1:0]      req_ready,
  output logic [NREQ-1:0]      rsp_push,
  output logic [31:0]          rsp_data,
  input  logic                 cfg_write,
  input  logic [11:0]          cfg_addr,
  input  logic [31:0]          cfg_wdata,
  output logic                 cfg_ready,
  output logic                 se_write,
  output logic [11:0]          se_addr,
  output logic [31:0]          se_wdata,
  output logic                 se_pushin,
  output logic [7:0]           se_datain,
  output logic [31:0]          se_entropy,
  input  logic                 se_pushout,
  input  logic [31:0]          se_dataout,
  output logic                 err_timeout,
  output logic                 err_unexp
);

  localparam int IW = $clog2(NREQ);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_CFG   = 2'd3;

  logic [1:0]      state_r;
  logic [1:0]      state_s;
  logic [IW-1:0]   rr_ptr_r;
  logic [CW-1:0]   outstanding_r;
  logic [AW-1:0]   wr_ptr_r;
  logic [AW-1:0]   rd_ptr_r;
  logic [IW-1:0]   tag_mem [DEPTH];
  logic [TW-1:0]   timer_r;

  logic [IW-1:0]   cand_s;
  logic [IW-1:0]   grant_idx_s;
  logic            grant_found_s;
  logic            grant_en_s;
  logic [NREQ-1:0] req_ready_s;
  logic            xfer_s;
  logic            pop_s;
  logic            unexp_s;
  logic [7:0]      data_sel_s;
  logic [31:0]     ent_sel_s;

  logic [NREQ-1:0] rsp_push_r;
  logic [31:0]     rsp_data_r;
  logic            cfg_ready_r;
  logic            se_write_r;
  logic [11:0]     se_addr_r;
  logic [31:0]     se_wdata_r;
  logic            se_pushin_r;
  logic [7:0]      se_datain_r;
  logic [31:0]     se_entropy_r;
  logic            err_timeout_r;
  logic            err_unexp_r;

  function automatic logic [NREQ-1:0] tag_onehot(input logic [IW-1:0] tag);
    logic [NREQ-1:0] oh;
    oh      = '0;
    oh[tag] = 1'b1;
    return oh;
  endfunction

  // Search for the first valid requester after the round-robin pointer, wrapping around.
  always_comb begin
    cand_s        = '0;
    grant_idx_s   = '0;
    grant_found_s = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      cand_s = (int'(rr_ptr_r) + k >= NREQ) ? IW'(int'(rr_ptr_r) + k - NREQ)
                                            : IW'(int'(rr_ptr_r) + k);
      if (!grant_found_s && req_valid[cand_s]) begin
        grant_found_s = 1'b1;
        grant_idx_s   = cand_s;
      end else begin
        grant_found_s = grant_found_s;
      end
    end
  end

  // A pending host write blocks new grants so the core can drain ahead of it.
  assign grant_en_s = ((state_r == ST_IDLE) || (state_r == ST_RUN)) && !cfg_write &&
                      (outstanding_r != CW'(DEPTH));

  // One-hot ready toward the selected requester.
  always_comb begin
    req_ready_s = '0;
    if (grant_en_s && grant_found_s) begin
      req_ready_s = tag_onehot(grant_idx_s);
    end else begin
      req_ready_s = '0;
    end
  end

  assign xfer_s  = |req_ready_s;
  assign pop_s   = se_pushout && (outstanding_r != '0);
  assign unexp_s = se_pushout && (outstanding_r == '0);

  // Mux the granted requester's byte and entropy onto the push path.
  always_comb begin
    data_sel_s = 8'h00;
    ent_sel_s  = 32'h0000_0000;
    for (int i = 0; i < NREQ; i++) begin
      data_sel_s = data_sel_s | (req_data[8*i +: 8] & {8{grant_idx_s == IW'(i)}});
      ent_sel_s  = ent_sel_s | (req_ent[32*i +: 32] & {32{grant_idx_s == IW'(i)}});
    end
  end

  // Next-state decode for the grant / drain / config sequencer.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (cfg_write && (outstanding_r == '0)) begin
          state_s = ST_CFG;
        end else if (xfer_s) begin
          state_s = ST_RUN;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (cfg_write) begin
          state_s = ST_DRAIN;
        end else if ((outstanding_r == '0) && !xfer_s) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RUN;
        end
      end
      ST_DRAIN: begin
        if (outstanding_r == '0) begin
          state_s = ST_CFG;
        end else begin
          state_s = ST_DRAIN;
        end
      end
      ST_CFG:  state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
  end

  // State, round-robin pointer, tag FIFO pointers and outstanding count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_r       <= ST_IDLE;
      rr_ptr_r      <= IW'(NREQ - 1);
      outstanding_r <= '0;
      wr_ptr_r      <= '0;
      rd_ptr_r      <= '0;
    end else begin
      state_r <= state_s;
      if (xfer_s) begin
        rr_ptr_r <= grant_idx_s;
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({xfer_s, pop_s})
        2'b10:   outstanding_r <= outstanding_r + CW'(1);
        2'b01:   outstanding_r <= outstanding_r - CW'(1);
        default: outstanding_r <= outstanding_r;
      endcase
    end
  end

  // Tag storage: the owning requester index for every push in flight.
  always_ff @(posedge clk) begin
    if (xfer_s) begin
      tag_mem[wr_ptr_r] <= grant_idx_s;
    end
  end

  // Core-facing push and config write registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      se_pushin_r  <= 1'b0;
      se_datain_r  <= 8'h00;
      se_entropy_r <= 32'h0000_0000;
      se_write_r   <= 1'b0;
      se_addr_r    <= 12'h000;
      se_wdata_r   <= 32'h0000_0000;
      cfg_ready_r  <= 1'b0;
    end else begin
      se_pushin_r  <= xfer_s;
      se_datain_r  <= xfer_s ? data_sel_s : 8'h00;
      se_entropy_r <= xfer_s ? ent_sel_s : 32'h0000_0000;
      se_write_r   <= (state_s == ST_CFG);
      se_addr_r    <= (state_s == ST_CFG) ? cfg_addr : 12'h000;
      se_wdata_r   <= (state_s == ST_CFG) ? cfg_wdata : 32'h0000_0000;
      cfg_ready_r  <= (state_s == ST_CFG);
    end
  end

  // Result return: rsp_data keeps its last value between strobes.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_push_r <= '0;
      rsp_data_r <= 32'h0000_0000;
    end else if (pop_s) begin
      rsp_push_r <= tag_onehot(tag_mem[rd_ptr_r]);
      rsp_data_r <= se_dataout;
    end else begin
      rsp_push_r <= '0;
    end
  end

  // Response watchdog and sticky error flags.
  always_ff @(posedge clk) begin
    if (!rst) begin
      timer_r       <= TW'(TIMEOUT);
      err_timeout_r <= 1'b0;
      err_unexp_r   <= 1'b0;
    end else begin
      if (se_pushout || (outstanding_r == '0)) begin
        timer_r <= TW'(TIMEOUT);
      end else if (timer_r != '0) begin
        timer_r <= timer_r - TW'(1);
        if (timer_r == TW'(1)) begin
          err_timeout_r <= 1'b1;
        end
      end
      if (unexp_s) begin
        err_unexp_r <= 1'b1;
      end
    end
  end

  assign req_ready   = req_ready_s;
  assign rsp_push    = rsp_push_r;
  assign rsp_data    = rsp_data_r;
  assign cfg_ready   = cfg_ready_r;
  assign se_write    = se_write_r;
  assign se_addr     = se_addr_r;
  assign se_wdata    = se_wdata_r;
  assign se_pushin   = se_pushin_r;
  assign se_datain   = se_datain_r;
  assign se_entropy  = se_entropy_r;
  assign err_timeout = err_timeout_r;
  assign err_unexp   = err_unexp_r;

endmodule
